// File: rtl/udp_tx_stream_packetizer_400g_pkg.sv
`default_nettype none
// ============================================================================
// Module      : udp400g_pkg
// Description : Shared constants, FSM state type, packet metadata struct and
//               beat-count helper for the 400G UDP TX stream packetizer.
// Revision    : 1.0 - initial release
// ============================================================================
package udp400g_pkg;

    localparam int BYTES_PER_BEAT = 128;
    localparam int BEAT_SHIFT     = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] ip;
        logic [15:0] dport;
        logic [15:0] sport;
        logic [15:0] len;
    } meta_t;

    // Beats per packet: whole beats in the byte length, at least one, at most max_beats.
    function automatic int unsigned calc_beats(input logic [15:0] len_bytes,
                                               input int unsigned max_beats);
        int unsigned n;
        n = 32'(len_bytes >> BEAT_SHIFT);
        if (n == 0)
            n = 1;
        else if (n > max_beats)
            n = max_beats;
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/udp_tx_stream_packetizer_400g_if.sv
`default_nettype none
// ============================================================================
// Module      : udp_tx_stream_packetizer_400g_if
// Description : Raw sample input stream and packetized AXIS output stream.
//               master = packetizer side, slave = surrounding environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface udp_tx_stream_packetizer_400g_if #(
    parameter int DATA_WIDTH = 1024
);
    logic [DATA_WIDTH-1:0]   s_axis_tdata;
    logic                    s_axis_tvalid;
    logic                    s_axis_tready;
    logic [DATA_WIDTH-1:0]   tx_tdata;
    logic                    tx_tvalid;
    logic                    tx_tready;
    logic [DATA_WIDTH/8-1:0] tx_tkeep;
    logic                    tx_tlast;
    logic                    tx_tuser;

    modport master (
        input  s_axis_tdata, s_axis_tvalid, tx_tready,
        output s_axis_tready, tx_tdata, tx_tvalid, tx_tkeep, tx_tlast, tx_tuser
    );

    modport slave (
        output s_axis_tdata, s_axis_tvalid, tx_tready,
        input  s_axis_tready, tx_tdata, tx_tvalid, tx_tkeep, tx_tlast, tx_tuser
    );
endinterface
`default_nettype wire

// File: rtl/axis_skid_slice.sv
`default_nettype none
// ============================================================================
// Module      : axis_skid_slice
// Description : Two-entry registered slice (output register + skid entry).
//               in_ready is a pure register so no combinational path runs
//               from out_ready back to the upstream handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_skid_slice #(
    parameter int G_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [G_WIDTH-1:0] in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [G_WIDTH-1:0] out_data,
    input  logic               out_ready
);
    logic               skid_valid;
    logic [G_WIDTH-1:0] skid_data;
    logic               in_fire;

    assign in_ready = !skid_valid;
    assign in_fire  = in_valid && !skid_valid;

    // Output register refills from the skid entry first; a beat arriving while stalled parks in skid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= in_fire;
                if (in_fire)
                    out_data <= in_data;
            end
        end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end
endmodule
`default_nettype wire

// File: rtl/udp_tx_stream_packetizer_400g.sv
`default_nettype none
// ============================================================================
// Module      : udp_tx_stream_packetizer_400g
// Description : Cuts an unframed 1024-bit sample stream into fixed-length UDP
//               payload packets, generating tlast/tkeep and per-packet
//               destination metadata for the 400G UDP streaming core.
// Revision    : 1.0 - initial release
// ============================================================================
module udp_tx_stream_packetizer_400g
    import udp400g_pkg::*;
#(
    parameter int G_AXIS_DATA_WIDTH = 1024,
    parameter int G_MAX_BEATS       = 70,
    parameter int G_LEN_WIDTH       = 16
) (
    input  logic                   axis_clk,
    input  logic                   axis_reset,
    input  logic                   cfg_enable,
    input  logic [G_LEN_WIDTH-1:0] cfg_packet_length,
    input  logic [31:0]            cfg_destination_ip,
    input  logic [15:0]            cfg_destination_udp_port,
    input  logic [15:0]            cfg_source_udp_port,
    input  logic                   flush,
    udp_tx_stream_packetizer_400g_if.master bus,
    output logic [31:0]            tx_destination_ip,
    output logic [15:0]            tx_destination_udp_port,
    output logic [15:0]            tx_source_udp_port,
    output logic [G_LEN_WIDTH-1:0] tx_packet_length,
    output logic [31:0]            stat_packet_count,
    output logic [31:0]            stat_flush_count
);
    localparam int CNT_W  = $clog2(G_MAX_BEATS);
    localparam int NB_W   = $clog2(G_MAX_BEATS + 1);
    localparam int KEEP_W = G_AXIS_DATA_WIDTH / 8;
    localparam int SLC_W  = G_AXIS_DATA_WIDTH + 1;

    state_t           state;
    logic [NB_W-1:0]  beats;
    logic [CNT_W-1:0] beat_cnt;
    logic             flush_pend;
    meta_t            meta;

    logic [NB_W-1:0]  beats_next;
    logic [15:0]      len_next;
    logic             slice_in_ready;
    logic             slice_out_valid;
    logic [SLC_W-1:0] slice_out_data;
    logic             accept;
    logic             last_beat;
    logic             flush_now;
    logic             tag_last;
    logic             load_ok;

    assign beats_next = NB_W'(calc_beats(16'(cfg_packet_length), 32'(G_MAX_BEATS)));
    assign len_next   = 16'(32'(beats_next) << BEAT_SHIFT);

    assign bus.s_axis_tready = (state == SEND) && slice_in_ready;
    assign accept    = bus.s_axis_tvalid && bus.s_axis_tready;
    assign last_beat = (NB_W'(beat_cnt) == beats - NB_W'(1));
    // A flush pulse in the same cycle as an accepted beat ends the packet on that beat.
    assign flush_now = flush_pend || flush;
    assign tag_last  = last_beat || flush_now;
    // Metadata may only move once the previous packet's tail has left the slice.
    assign load_ok   = !bus.tx_tvalid || (bus.tx_tready && slice_in_ready);

    // Packet FSM: latch length and metadata at packet start, count beats, tag the last one.
    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            state            <= IDLE;
            beats            <= '0;
            beat_cnt         <= '0;
            flush_pend       <= 1'b0;
            meta             <= '0;
            stat_flush_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    flush_pend <= 1'b0;
                    if (cfg_enable)
                        state <= LOAD;
                end
                LOAD: begin
                    flush_pend <= 1'b0;
                    if (load_ok) begin
                        beats    <= beats_next;
                        beat_cnt <= '0;
                        meta     <= '{ip: cfg_destination_ip, dport: cfg_destination_udp_port,
                                      sport: cfg_source_udp_port, len: len_next};
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (accept) begin
                        if (tag_last) begin
                            beat_cnt   <= '0;
                            flush_pend <= 1'b0;
                            state      <= cfg_enable ? LOAD : IDLE;
                            if (flush_now && !last_beat)
                                stat_flush_count <= stat_flush_count + 32'd1;
                        end else begin
                            beat_cnt   <= beat_cnt + CNT_W'(1);
                            flush_pend <= 1'b0;
                        end
                    end else begin
                        flush_pend <= flush_now;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Completed packets are counted on the downstream tlast handshake.
    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset)
            stat_packet_count <= '0;
        else if (bus.tx_tvalid && bus.tx_tready && bus.tx_tlast)
            stat_packet_count <= stat_packet_count + 32'd1;
    end

    axis_skid_slice #(
        .G_WIDTH(SLC_W)
    ) u_slice (
        .clk      (axis_clk),
        .rst      (axis_reset),
        .in_valid (bus.s_axis_tvalid && (state == SEND)),
        .in_data  ({tag_last, bus.s_axis_tdata}),
        .in_ready (slice_in_ready),
        .out_valid(slice_out_valid),
        .out_data (slice_out_data),
        .out_ready(bus.tx_tready)
    );

    assign bus.tx_tvalid = slice_out_valid;
    assign bus.tx_tdata  = slice_out_data[G_AXIS_DATA_WIDTH-1:0];
    assign bus.tx_tlast  = slice_out_data[G_AXIS_DATA_WIDTH];
    assign bus.tx_tkeep  = {KEEP_W{slice_out_valid}};
    assign bus.tx_tuser  = 1'b0;

    assign tx_destination_ip       = meta.ip;
    assign tx_destination_udp_port = meta.dport;
    assign tx_source_udp_port      = meta.sport;
    assign tx_packet_length        = G_LEN_WIDTH'(meta.len);
endmodule
`default_nettype wire

// File: tb/tb_udp_tx_stream_packetizer_400g.sv
`default_nettype none
// ============================================================================
// Module      : tb_udp_tx_stream_packetizer_400g
// Description : Self-checking bench; a queue-based reference model predicts
//               every output beat and per-packet metadata from the stream of
//               accepted input beats and the configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_udp_tx_stream_packetizer_400g;
    localparam int DW   = 1024;
    localparam int MAXB = 70;

    logic        axis_clk = 1'b0;
    logic        axis_reset = 1'b1;
    logic        cfg_enable = 1'b0;
    logic [15:0] cfg_packet_length = 16'd1024;
    logic [31:0] cfg_destination_ip = 32'hc0a80103;
    logic [15:0] cfg_destination_udp_port = 16'd7148;
    logic [15:0] cfg_source_udp_port = 16'd10000;
    logic        flush = 1'b0;
    logic [31:0] tx_destination_ip;
    logic [15:0] tx_destination_udp_port;
    logic [15:0] tx_source_udp_port;
    logic [15:0] tx_packet_length;
    logic [31:0] stat_packet_count;
    logic [31:0] stat_flush_count;

    udp_tx_stream_packetizer_400g_if #(.DATA_WIDTH(DW)) bus ();

    udp_tx_stream_packetizer_400g dut (
        .axis_clk                (axis_clk),
        .axis_reset              (axis_reset),
        .cfg_enable              (cfg_enable),
        .cfg_packet_length       (cfg_packet_length),
        .cfg_destination_ip      (cfg_destination_ip),
        .cfg_destination_udp_port(cfg_destination_udp_port),
        .cfg_source_udp_port     (cfg_source_udp_port),
        .flush                   (flush),
        .bus                     (bus),
        .tx_destination_ip       (tx_destination_ip),
        .tx_destination_udp_port (tx_destination_udp_port),
        .tx_source_udp_port      (tx_source_udp_port),
        .tx_packet_length        (tx_packet_length),
        .stat_packet_count       (stat_packet_count),
        .stat_flush_count        (stat_flush_count)
    );

    always #5 axis_clk = ~axis_clk;

    typedef struct { logic [DW-1:0] data; logic last; } beat_t;
    typedef struct packed { logic [31:0] ip; logic [15:0] dp; logic [15:0] sp; logic [15:0] len; } pmeta_t;

    beat_t       exp_q[$];
    pmeta_t      meta_q[$];
    int          in_idx = 0;
    int          cur_n = 1;
    bit          flush_pend_m = 0;
    int          exp_pkts = 0;
    int          exp_flush = 0;
    int          tests = 0;
    int          fails = 0;
    bit          prev_stall = 0;
    logic [DW-1:0] prev_data;
    logic        prev_last;
    bit          chk_rate = 0;
    bit          last_acc = 0;
    logic [31:0] seq = 32'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wide(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed[63:0]=%0h expected[63:0]=%0h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    function automatic int ref_beats(input int len);
        int n;
        n = len / 128;
        if (n < 1) n = 1;
        if (n > MAXB) n = MAXB;
        return n;
    endfunction

    function automatic logic [DW-1:0] new_data(input logic [31:0] s);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        d[31:0] = s;
        return d;
    endfunction

    // One clock: observe the interval after the negedge, update the model, wait for the next negedge.
    task automatic cycle();
        beat_t  b;
        pmeta_t m;
        bit     s_acc, t_hs;
        #1;
        s_acc = bus.s_axis_tvalid && bus.s_axis_tready;
        t_hs  = bus.tx_tvalid && bus.tx_tready;
        if (prev_stall) begin
            chk("stall_tvalid", 64'(bus.tx_tvalid), 64'd1);
            chk_wide("stall_tdata", bus.tx_tdata, prev_data);
            chk("stall_tlast", 64'(bus.tx_tlast), 64'(prev_last));
        end
        if (chk_rate && in_idx > 0 && bus.s_axis_tvalid)
            chk("full_rate_tready", 64'(bus.s_axis_tready), 64'd1);
        if (t_hs) begin
            chk("beat_expected", 64'(exp_q.size() > 0 && meta_q.size() > 0), 64'd1);
            if (exp_q.size() > 0 && meta_q.size() > 0) begin
                b = exp_q.pop_front();
                m = meta_q[0];
                chk_wide("tdata", bus.tx_tdata, b.data);
                chk("tlast", 64'(bus.tx_tlast), 64'(b.last));
                chk("tkeep_all_ones", 64'(&bus.tx_tkeep), 64'd1);
                chk("tuser", 64'(bus.tx_tuser), 64'd0);
                chk("meta_ip", 64'(tx_destination_ip), 64'(m.ip));
                chk("meta_dport", 64'(tx_destination_udp_port), 64'(m.dp));
                chk("meta_sport", 64'(tx_source_udp_port), 64'(m.sp));
                chk("meta_len", 64'(tx_packet_length), 64'(m.len));
                if (b.last) begin
                    meta_q.delete(0);
                    exp_pkts++;
                end
            end
        end
        if (s_acc) begin
            if (in_idx == 0) begin
                cur_n = ref_beats(int'(cfg_packet_length));
                m = {cfg_destination_ip, cfg_destination_udp_port, cfg_source_udp_port, 16'(cur_n * 128)};
                meta_q.push_back(m);
            end
            b.data = bus.s_axis_tdata;
            b.last = (in_idx == cur_n - 1) || flush_pend_m || flush;
            if (b.last && in_idx != cur_n - 1) exp_flush++;
            exp_q.push_back(b);
            in_idx = b.last ? 0 : in_idx + 1;
            flush_pend_m = 0;
        end else if (flush && in_idx > 0) begin
            flush_pend_m = 1;
        end
        last_acc   = s_acc;
        prev_stall = bus.tx_tvalid && !bus.tx_tready;
        prev_data  = bus.tx_tdata;
        prev_last  = bus.tx_tlast;
        @(negedge axis_clk);
    endtask

    // Offer beats until n_acc are accepted. mode 0: tready=1; 1: tready toggles; 2: random valid/ready.
    // flush/stop(enable=0)/ip change are applied on the accepting cycle of the given beat index.
    task automatic stream(input int n_acc, input int mode, input int flush_at, input int stop_at,
                          input int ip_at, input logic [31:0] new_ip);
        int acc = 0;
        int guard = 0;
        bit need_new = 1;
        chk_rate = (mode == 0);
        while (acc < n_acc && guard < 40 * n_acc + 100) begin
            if (need_new) begin
                bus.s_axis_tdata = new_data(seq);
                need_new = 0;
            end
            bus.s_axis_tvalid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            case (mode)
                0:       bus.tx_tready = 1'b1;
                1:       bus.tx_tready = (guard % 2 == 0);
                default: bus.tx_tready = 1'($urandom_range(0, 1));
            endcase
            flush = 1'b0;
            if (bus.s_axis_tvalid && bus.s_axis_tready) begin
                if (acc == flush_at) flush = 1'b1;
                if (acc == stop_at)  cfg_enable = 1'b0;
                if (acc == ip_at)    cfg_destination_ip = new_ip;
            end
            cycle();
            if (last_acc) begin
                acc++;
                seq++;
                need_new = 1;
            end
            guard++;
        end
        flush = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        chk("stream_accepted", 64'(acc), 64'(n_acc));
    endtask

    task automatic drain();
        int g = 0;
        chk_rate = 0;
        bus.s_axis_tvalid = 1'b0;
        bus.tx_tready = 1'b1;
        flush = 1'b0;
        while ((exp_q.size() != 0 || bus.tx_tvalid) && g < 300) begin
            cycle();
            g++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        repeat (3) cycle();
        chk("stat_packet_count", 64'(stat_packet_count), 64'(exp_pkts));
        chk("stat_flush_count", 64'(stat_flush_count), 64'(exp_flush));
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_tvalid"}, 64'(bus.tx_tvalid), 64'd0);
        chk({tag, "_tlast"}, 64'(bus.tx_tlast), 64'd0);
        chk_wide({tag, "_tdata"}, bus.tx_tdata, '0);
        chk({tag, "_tkeep"}, 64'(|bus.tx_tkeep), 64'd0);
        chk({tag, "_s_tready"}, 64'(bus.s_axis_tready), 64'd0);
        chk({tag, "_ip"}, 64'(tx_destination_ip), 64'd0);
        chk({tag, "_ports"}, 64'({tx_destination_udp_port, tx_source_udp_port}), 64'd0);
        chk({tag, "_len"}, 64'(tx_packet_length), 64'd0);
        chk({tag, "_counts"}, 64'({stat_packet_count, stat_flush_count}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lens[3];
        int n;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.tx_tready     = 1'b1;

        // Reset state
        @(negedge axis_clk);
        @(negedge axis_clk);
        #1;
        chk_zero_outputs("reset");
        @(negedge axis_clk);
        axis_reset = 1'b0;
        repeat (2) cycle();

        // 1: three contiguous 8-beat packets at full rate
        cfg_packet_length = 16'd1024;
        cfg_enable = 1'b1;
        stream(24, 0, -1, 16, -1, 32'h0);
        drain();
        chk("t1_packets", 64'(stat_packet_count), 64'd3);
        chk("t1_idle_tready", 64'(bus.s_axis_tready), 64'd0);

        // 2: length rounding / clamping
        lens[0] = 1100; lens[1] = 0; lens[2] = 65535;
        for (int i = 0; i < 3; i++) begin
            cfg_packet_length = 16'(lens[i]);
            cfg_enable = 1'b1;
            stream(ref_beats(lens[i]), 0, -1, 0, -1, 32'h0);
            drain();
        end

        // 3: toggling backpressure, then random valid/ready with random config
        cfg_packet_length = 16'd1024;
        cfg_enable = 1'b1;
        stream(16, 1, -1, 8, -1, 32'h0);
        drain();
        for (int i = 0; i < 3; i++) begin
            cfg_packet_length        = 16'($urandom_range(0, 2000));
            cfg_destination_ip       = $urandom;
            cfg_destination_udp_port = 16'($urandom);
            cfg_source_udp_port      = 16'($urandom);
            n = ref_beats(int'(cfg_packet_length));
            cfg_enable = 1'b1;
            stream(3 * n, 2, -1, 2 * n, -1, 32'h0);
            drain();
        end

        // 4: flush at beat 3, new IP for the following packet; flush in IDLE; flush on final beat
        cfg_packet_length  = 16'd1024;
        cfg_destination_ip = 32'hc0a80103;
        cfg_enable = 1'b1;
        stream(20, 0, 3, 12, 1, 32'hc0a80105);
        drain();
        chk("t4_flush_count", 64'(stat_flush_count), 64'(exp_flush));
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycle();
        cfg_enable = 1'b1;
        stream(8, 0, -1, 0, -1, 32'h0);
        drain();
        cfg_enable = 1'b1;
        stream(8, 0, 7, 0, -1, 32'h0);
        drain();

        // 5: IP changes mid-packet; enable dropped mid-packet completes the packet
        cfg_destination_ip = 32'hc0a80103;
        cfg_enable = 1'b1;
        stream(16, 0, -1, 9, 3, 32'hc0a80104);
        drain();
        repeat (4) cycle();
        chk("t5_idle_tready", 64'(bus.s_axis_tready), 64'd0);
        chk("t5_idle_tvalid", 64'(bus.tx_tvalid), 64'd0);

        // 6: reset mid-packet, then a full packet after release
        cfg_enable = 1'b1;
        stream(5, 0, -1, -1, -1, 32'h0);
        #2;
        axis_reset = 1'b1;
        #1;
        chk_zero_outputs("midreset");
        exp_q.delete();
        meta_q.delete();
        in_idx = 0;
        flush_pend_m = 0;
        exp_pkts = 0;
        exp_flush = 0;
        prev_stall = 0;
        @(negedge axis_clk);
        @(negedge axis_clk);
        axis_reset = 1'b0;
        stream(8, 0, -1, 0, -1, 32'h0);
        drain();
        chk("t6_packets", 64'(stat_packet_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
